bus_mem_responder: RTL and testbench

- Responder (slave) end of the CPU core's BUS_* handshake interface; sits on the far side of the bus from the core's bus controller.
- Decodes a word-addressed window starting at ADDR_BASE and serves single-word reads and writes from an internal memory array.
- Inserts WAIT_CYCLES programmable wait states so initiator stall paths are exercised.
- Serves as the program/data memory model for system bring-up and as the reference responder for bus-controller verification.

---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_mem_responder_if.sv | 25 ++
 rtl/bus_resp_sram.sv | 42 ++++
 rtl/bus_mem_responder.sv | 141 ++++++++++++++
 tb/tb_bus_mem_responder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the BUS_* handshake: widths, mode encoding and the
// responder state encoding. Both the initiator and responder sides import this.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;

  localparam logic BUS_MODE_READ  = 1'b0;
  localparam logic BUS_MODE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    RESP_IDLE  = 3'd0,
    RESP_WAIT  = 3'd1,
    RESP_WRESP = 3'd2,
    RESP_RRESP = 3'd3,
    RESP_DONE  = 3'd4
  } resp_state_e;

endpackage

// File: rtl/bus_mem_responder_if.sv
// BUS_* handshake bundle between the core's bus controller (master) and a
// memory responder (slave).
interface bus_mem_responder_if;
  import bus_pkg::*;

  logic [BUS_ADDR_W-1:0] BUS_addr;
  logic [BUS_DATA_W-1:0] BUS_wdata;
  logic                  BUS_mode;
  logic                  BUS_valid;
  logic                  BUS_wready;
  logic                  BUS_rvalid;
  logic                  BUS_rready;
  logic [BUS_DATA_W-1:0] BUS_rdata;

  modport master (
    output BUS_addr, BUS_wdata, BUS_mode, BUS_valid, BUS_rready,
    input  BUS_wready, BUS_rvalid, BUS_rdata
  );

  modport slave (
    input  BUS_addr, BUS_wdata, BUS_mode, BUS_valid, BUS_rready,
    output BUS_wready, BUS_rvalid, BUS_rdata
  );

endinterface

// File: rtl/bus_resp_sram.sv
// Single-port synchronous word array with registered read. The array itself
// is never reset; only the read register returns to zero on rst.
module bus_resp_sram #(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic          re_i,
  input  logic          rclr_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Array write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register; rclr_i loads zero for out-of-window reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'h0000_0000;
    end else if (rclr_i) begin
      rdata_q <= 32'h0000_0000;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Memory responder on the BUS_* handshake: window decode, programmable wait
// states and single-word read/write against bus_resp_sram.
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  bus_mem_responder_if.slave  bus,
  output logic                oor_hit
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  resp_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          mode_q, mode_d;
  logic          in_range_q, in_range_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wready_q, wready_d;
  logic          rvalid_q, rvalid_d;
  logic          oor_q, oor_d;

  logic [31:0]   off_s;
  logic          in_range_s;
  logic [AW-1:0] idx_s;
  logic          enter_resp_s;
  logic          resp_in_range_s;
  logic          sram_we_s;
  logic          sram_re_s;
  logic          sram_rclr_s;
  logic [AW-1:0] sram_addr_s;
  logic [31:0]   sram_rdata_s;

  assign off_s      = bus.BUS_addr - ADDR_BASE;
  assign in_range_s = (off_s < WIN_BYTES);
  assign idx_s      = off_s[AW+1:2];

  // Next-state and request latching
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    mode_d     = mode_q;
    in_range_d = in_range_q;
    idx_d      = idx_q;
    case (state_q)
      RESP_IDLE: begin
        if (bus.BUS_valid) begin
          wdata_d    = bus.BUS_wdata;
          mode_d     = bus.BUS_mode;
          in_range_d = in_range_s;
          idx_d      = idx_s;
          cnt_d      = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d = (bus.BUS_mode == BUS_MODE_WRITE) ? RESP_WRESP : RESP_RRESP;
          end else begin
            state_d = RESP_WAIT;
          end
        end else begin
          state_d = RESP_IDLE;
        end
      end
      RESP_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = (mode_q == BUS_MODE_WRITE) ? RESP_WRESP : RESP_RRESP;
        end else begin
          state_d = RESP_WAIT;
        end
      end
      RESP_WRESP: state_d = RESP_DONE;
      RESP_RRESP: state_d = bus.BUS_rready ? RESP_DONE : RESP_RRESP;
      // Hold off until valid drops so a sticky request is not replayed
      RESP_DONE:  state_d = bus.BUS_valid ? RESP_DONE : RESP_IDLE;
      default:    state_d = RESP_IDLE;
    endcase
  end

  // With zero wait states the response is entered straight from IDLE, so the
  // live decode must be used instead of the latched one.
  assign enter_resp_s    = ((state_q == RESP_IDLE) || (state_q == RESP_WAIT)) &&
                           ((state_d == RESP_WRESP) || (state_d == RESP_RRESP));
  assign resp_in_range_s = (state_q == RESP_IDLE) ? in_range_s : in_range_q;
  assign sram_addr_s     = (state_q == RESP_IDLE) ? idx_s : idx_q;
  assign sram_we_s       = (state_q == RESP_WRESP) && in_range_q;
  assign sram_re_s       = enter_resp_s && (state_d == RESP_RRESP) && resp_in_range_s;
  assign sram_rclr_s     = enter_resp_s && (state_d == RESP_RRESP) && !resp_in_range_s;

  assign wready_d = (state_d == RESP_WRESP);
  assign rvalid_d = (state_d == RESP_RRESP);
  assign oor_d    = enter_resp_s && !resp_in_range_s;

  // State, transaction and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESP_IDLE;
      cnt_q      <= 4'd0;
      wdata_q    <= 32'h0000_0000;
      mode_q     <= BUS_MODE_READ;
      in_range_q <= 1'b0;
      idx_q      <= '0;
      wready_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      mode_q     <= mode_d;
      in_range_q <= in_range_d;
      idx_q      <= idx_d;
      wready_q   <= wready_d;
      rvalid_q   <= rvalid_d;
      oor_q      <= oor_d;
    end
  end

  bus_resp_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (sram_we_s),
    .re_i    (sram_re_s),
    .rclr_i  (sram_rclr_s),
    .addr_i  (sram_addr_s),
    .wdata_i (wdata_q),
    .rdata_o (sram_rdata_s)
  );

  assign bus.BUS_wready = wready_q;
  assign bus.BUS_rvalid = rvalid_q;
  assign bus.BUS_rdata  = sram_rdata_s;
  assign oor_hit        = oor_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench: one responder with two wait states, one with none.
module tb_bus_mem_responder;

  logic clk;
  logic rst;
  logic oor_a;
  logic oor_b;
  int   n_checks;
  int   n_errors;

  bus_mem_responder_if bus_a ();
  bus_mem_responder_if bus_b ();

  bus_mem_responder #(.ADDR_BASE(32'h0000_0000), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .oor_hit(oor_a)
  );

  bus_mem_responder #(.ADDR_BASE(32'h0000_0000), .DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .oor_hit(oor_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Write on dut_a starting in IDLE; request bits are scrambled after acceptance
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic exp_oor);
    bus_a.BUS_addr  = addr;
    bus_a.BUS_wdata = data;
    bus_a.BUS_mode  = 1'b1;
    bus_a.BUS_valid = 1'b1;
    tick();
    bus_a.BUS_valid = 1'b0;
    bus_a.BUS_addr  = ~addr;
    bus_a.BUS_wdata = ~data;
    bus_a.BUS_mode  = 1'b0;
    chk1("wr_t1_wready", bus_a.BUS_wready, 1'b0);
    tick();
    chk1("wr_t2_wready", bus_a.BUS_wready, 1'b0);
    tick();
    chk1("wr_t3_wready", bus_a.BUS_wready, 1'b1);
    chk1("wr_t3_oor", oor_a, exp_oor);
    tick();
    chk1("wr_t4_wready", bus_a.BUS_wready, 1'b0);
    chk1("wr_t4_oor", oor_a, 1'b0);
    tick();
  endtask

  // Read on dut_a with rready already high before rvalid rises
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_oor);
    bus_a.BUS_addr   = addr;
    bus_a.BUS_mode   = 1'b0;
    bus_a.BUS_valid  = 1'b1;
    bus_a.BUS_rready = 1'b1;
    tick();
    bus_a.BUS_valid = 1'b0;
    bus_a.BUS_addr  = ~addr;
    bus_a.BUS_mode  = 1'b1;
    chk1("rd_t1_rvalid", bus_a.BUS_rvalid, 1'b0);
    tick();
    chk1("rd_t2_rvalid", bus_a.BUS_rvalid, 1'b0);
    tick();
    chk1("rd_t3_rvalid", bus_a.BUS_rvalid, 1'b1);
    chk32("rd_t3_rdata", bus_a.BUS_rdata, exp_data);
    chk1("rd_t3_oor", oor_a, exp_oor);
    tick();
    chk1("rd_t4_rvalid", bus_a.BUS_rvalid, 1'b0);
    chk32("rd_t4_rdata_hold", bus_a.BUS_rdata, exp_data);
    chk1("rd_t4_oor", oor_a, 1'b0);
    bus_a.BUS_rready = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus_a.BUS_addr = 32'h0; bus_a.BUS_wdata = 32'h0; bus_a.BUS_mode = 1'b0;
    bus_a.BUS_valid = 1'b0; bus_a.BUS_rready = 1'b0;
    bus_b.BUS_addr = 32'h0; bus_b.BUS_wdata = 32'h0; bus_b.BUS_mode = 1'b0;
    bus_b.BUS_valid = 1'b0; bus_b.BUS_rready = 1'b0;
    tick();
    tick();
    chk1("rst_a_wready", bus_a.BUS_wready, 1'b0);
    chk1("rst_a_rvalid", bus_a.BUS_rvalid, 1'b0);
    chk32("rst_a_rdata", bus_a.BUS_rdata, 32'h0);
    chk1("rst_a_oor", oor_a, 1'b0);
    chk1("rst_b_wready", bus_b.BUS_wready, 1'b0);
    chk1("rst_b_rvalid", bus_b.BUS_rvalid, 1'b0);
    rst = 1'b0;
    tick();

    do_write(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);

    // Read with rready held low: rvalid/rdata must stay put
    bus_a.BUS_addr = 32'h0000_0010; bus_a.BUS_mode = 1'b0; bus_a.BUS_valid = 1'b1;
    tick();
    bus_a.BUS_valid = 1'b0;
    chk1("slow_t1_rvalid", bus_a.BUS_rvalid, 1'b0);
    tick();
    chk1("slow_t2_rvalid", bus_a.BUS_rvalid, 1'b0);
    tick();
    chk1("slow_t3_rvalid", bus_a.BUS_rvalid, 1'b1);
    chk32("slow_t3_rdata", bus_a.BUS_rdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("slow_hold_rvalid", bus_a.BUS_rvalid, 1'b1);
      chk32("slow_hold_rdata", bus_a.BUS_rdata, 32'hDEAD_BEEF);
    end
    bus_a.BUS_rready = 1'b1;
    tick();
    chk1("slow_after_rvalid", bus_a.BUS_rvalid, 1'b0);
    chk32("slow_after_rdata", bus_a.BUS_rdata, 32'hDEAD_BEEF);
    bus_a.BUS_rready = 1'b0;
    tick();

    // Valid held high across completion: a single wready pulse only
    bus_a.BUS_addr = 32'h0000_0020; bus_a.BUS_wdata = 32'hAAAA_5555;
    bus_a.BUS_mode = 1'b1; bus_a.BUS_valid = 1'b1;
    tick();
    chk1("held_t1_wready", bus_a.BUS_wready, 1'b0);
    tick();
    chk1("held_t2_wready", bus_a.BUS_wready, 1'b0);
    tick();
    chk1("held_t3_wready", bus_a.BUS_wready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("held_done_wready", bus_a.BUS_wready, 1'b0);
    end
    bus_a.BUS_valid = 1'b0;
    tick();
    do_read(32'h0000_0020, 32'hAAAA_5555, 1'b0);

    // Out-of-window write aliases onto word 0 if decode is wrong
    do_write(32'h0000_0000, 32'h1111_2222, 1'b0);
    do_write(32'h0000_1000, 32'hFFFF_FFFF, 1'b1);
    do_read(32'h0000_1000, 32'h0000_0000, 1'b1);
    do_read(32'h0000_0002, 32'h1111_2222, 1'b0);

    // Reset during WAIT of a write: aborted, word 0x10 untouched
    bus_a.BUS_addr = 32'h0000_0010; bus_a.BUS_wdata = 32'h5A5A_5A5A;
    bus_a.BUS_mode = 1'b1; bus_a.BUS_valid = 1'b1;
    tick();
    bus_a.BUS_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk1("abort_wready", bus_a.BUS_wready, 1'b0);
    chk32("abort_rdata", bus_a.BUS_rdata, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk1("abort_no_wready", bus_a.BUS_wready, 1'b0);
    do_read(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);

    // Reset while rvalid is up clears outputs without a clock edge
    bus_a.BUS_addr = 32'h0000_0000; bus_a.BUS_mode = 1'b0; bus_a.BUS_valid = 1'b1;
    tick();
    bus_a.BUS_valid = 1'b0;
    tick();
    tick();
    chk1("arst_pre_rvalid", bus_a.BUS_rvalid, 1'b1);
    chk32("arst_pre_rdata", bus_a.BUS_rdata, 32'h1111_2222);
    #2 rst = 1'b1;
    #1;
    chk1("arst_rvalid", bus_a.BUS_rvalid, 1'b0);
    chk32("arst_rdata", bus_a.BUS_rdata, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    do_read(32'h0000_0000, 32'h1111_2222, 1'b0);

    // Zero wait states on dut_b
    bus_b.BUS_addr = 32'h0000_0000; bus_b.BUS_wdata = 32'h1234_5678;
    bus_b.BUS_mode = 1'b1; bus_b.BUS_valid = 1'b1;
    tick();
    bus_b.BUS_valid = 1'b0;
    chk1("b_wr_t1_wready", bus_b.BUS_wready, 1'b1);
    tick();
    chk1("b_wr_t2_wready", bus_b.BUS_wready, 1'b0);
    tick();
    bus_b.BUS_addr = 32'h0000_0003; bus_b.BUS_mode = 1'b0;
    bus_b.BUS_valid = 1'b1; bus_b.BUS_rready = 1'b1;
    tick();
    bus_b.BUS_valid = 1'b0;
    chk1("b_rd_t1_rvalid", bus_b.BUS_rvalid, 1'b1);
    chk32("b_rd_t1_rdata", bus_b.BUS_rdata, 32'h1234_5678);
    chk1("b_rd_t1_oor", oor_b, 1'b0);
    tick();
    chk1("b_rd_t2_rvalid", bus_b.BUS_rvalid, 1'b0);
    tick();
    bus_b.BUS_addr = 32'h0000_0040; bus_b.BUS_valid = 1'b1;
    tick();
    bus_b.BUS_valid = 1'b0;
    chk1("b_oor_rvalid", bus_b.BUS_rvalid, 1'b1);
    chk32("b_oor_rdata", bus_b.BUS_rdata, 32'h0);
    chk1("b_oor_hit", oor_b, 1'b1);
    tick();
    chk1("b_oor_hit_clear", oor_b, 1'b0);
    bus_b.BUS_rready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
